// File: rtl/pc_unit_if.sv
// Fetch-side bundle between the fetch controller (master) and the program-counter
// unit (slave): control strobes in, PC and return-stack status out.
interface pc_unit_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic             pc_en;
  logic             trap;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             ras_push;
  logic             ras_pop;

  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;
  logic [CNT_W-1:0] ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             misalign;
  logic             ras_underflow;

  modport master (
    output pc_en, trap, redirect_valid, redirect_target, ras_push, ras_pop,
    input  pc_out, pc_plus, ras_top, ras_count, ras_empty, ras_full,
           misalign, ras_underflow
  );

  modport slave (
    input  pc_en, trap, redirect_valid, redirect_target, ras_push, ras_pop,
    output pc_out, pc_plus, ras_top, ras_count, ras_empty, ras_full,
           misalign, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit: selects next PC from trap, redirect, return-stack pop or
// sequential increment, and keeps a circular return-address stack.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC   = WIDTH'('h4),
  parameter int               INC        = 4,
  parameter int               ALIGN_BITS = 2,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_unit_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    ~((WIDTH'(1) << ALIGN_BITS) - WIDTH'(1));

  function automatic logic [WIDTH-1:0] align_tgt(input logic [WIDTH-1:0] t);
    return t & ALIGN_MASK;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(RAS_DEPTH)) ? c : c + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;
  logic             uflow_q, uflow_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;

  assign pc_plus   = pc_q + WIDTH'(INC);
  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_empty ? '0 : ras_q[ptr_q];

  always_comb begin
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    uflow_d    = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = ptr_q;
    if (bus.trap) begin
      // Trap wins even over a stall; return stack is flushed but ptr kept.
      pc_d  = align_tgt(TRAP_VEC);
      cnt_d = '0;
    end else if (bus.pc_en) begin
      if (bus.redirect_valid) begin
        pc_d       = align_tgt(bus.redirect_target);
        misalign_d = ((bus.redirect_target & ~ALIGN_MASK) != '0);
      end else if (bus.ras_push && bus.ras_pop && !ras_empty) begin
        pc_d  = align_tgt(ras_top);
        wr_en = 1'b1;
      end else if (bus.ras_push) begin
        pc_d   = pc_plus;
        wr_en  = 1'b1;
        wr_idx = ptr_q + PTR_W'(1);
        ptr_d  = ptr_q + PTR_W'(1);
        cnt_d  = sat_inc(cnt_q);
      end else if (bus.ras_pop && !ras_empty) begin
        pc_d  = align_tgt(ras_top);
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d    = pc_plus;
        uflow_d = bus.ras_pop;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      ptr_q      <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      uflow_q    <= uflow_d;
    end
  end

  // Stack storage carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= pc_plus;
  end

  assign bus.pc_out        = pc_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.ras_top       = ras_top;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
  assign bus.misalign      = misalign_q;
  assign bus.ras_underflow = uflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: each stimulus cycle queues its hand-computed
// expected state; an independent monitor compares after every rising edge.
module tb_pc_unit;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic [31:0] top;
    logic        mis;
    logic        uf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  pc_unit_if #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) bus ();
  pc_unit #(.WIDTH(WIDTH), .RAS_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input string fld,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endfunction

  task automatic step(input string nm, input logic r, input logic en, input logic tr,
                      input logic rv, input logic [31:0] tgt, input logic pu,
                      input logic po, input logic [31:0] epc, input logic [2:0] ecnt,
                      input logic [31:0] etop, input logic emis, input logic euf);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    bus.pc_en           = en;
    bus.trap            = tr;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.ras_push        = pu;
    bus.ras_pop         = po;
    e.name = nm; e.pc = epc; e.cnt = ecnt; e.top = etop; e.mis = emis; e.uf = euf;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pc_out",    bus.pc_out,           e.pc);
        chk(e.name, "pc_plus",   bus.pc_plus,          e.pc + 32'd4);
        chk(e.name, "ras_count", 32'(bus.ras_count),   32'(e.cnt));
        chk(e.name, "ras_top",   bus.ras_top,          e.top);
        chk(e.name, "ras_full",  32'(bus.ras_full),    32'(e.cnt == 3'd4));
        chk(e.name, "ras_empty", 32'(bus.ras_empty),   32'(e.cnt == 3'd0));
        chk(e.name, "misalign",  32'(bus.misalign),    32'(e.mis));
        chk(e.name, "underflow", 32'(bus.ras_underflow), 32'(e.uf));
      end
    end
  end

  initial begin : stimulus
    int waited;
    bus.pc_en = 1'b0; bus.trap = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_target = '0; bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
    //    name          rst en tr rv target        pu po  pc            cnt top           mis uf
    step("reset",       1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 0);
    step("seq1",        0, 1, 0, 0, 32'h0,        0, 0, 32'h4,        0, 32'h0,        0, 0);
    step("seq2",        0, 1, 0, 0, 32'h0,        0, 0, 32'h8,        0, 32'h0,        0, 0);
    step("seq3",        0, 1, 0, 0, 32'h0,        0, 0, 32'hC,        0, 32'h0,        0, 0);
    step("stall_redir", 0, 0, 0, 1, 32'h100,      0, 0, 32'hC,        0, 32'h0,        0, 0);
    step("stall_trap",  0, 0, 1, 0, 32'h0,        0, 0, 32'h4,        0, 32'h0,        0, 0);
    step("to_10a",      0, 1, 0, 0, 32'h0,        0, 0, 32'h8,        0, 32'h0,        0, 0);
    step("to_10b",      0, 1, 0, 0, 32'h0,        0, 0, 32'hC,        0, 32'h0,        0, 0);
    step("to_10c",      0, 1, 0, 0, 32'h0,        0, 0, 32'h10,       0, 32'h0,        0, 0);
    step("call_10",     0, 1, 0, 0, 32'h0,        1, 0, 32'h14,       1, 32'h14,       0, 0);
    step("jump_80",     0, 1, 0, 1, 32'h80,       0, 0, 32'h80,       1, 32'h14,       0, 0);
    step("ret_80",      0, 1, 0, 0, 32'h0,        0, 1, 32'h14,       0, 32'h0,        0, 0);
    step("push1",       0, 1, 0, 0, 32'h0,        1, 0, 32'h18,       1, 32'h18,       0, 0);
    step("push2",       0, 1, 0, 0, 32'h0,        1, 0, 32'h1C,       2, 32'h1C,       0, 0);
    step("push3",       0, 1, 0, 0, 32'h0,        1, 0, 32'h20,       3, 32'h20,       0, 0);
    step("push4",       0, 1, 0, 0, 32'h0,        1, 0, 32'h24,       4, 32'h24,       0, 0);
    step("push5_wrap",  0, 1, 0, 0, 32'h0,        1, 0, 32'h28,       4, 32'h28,       0, 0);
    step("pop1",        0, 1, 0, 0, 32'h0,        0, 1, 32'h28,       3, 32'h24,       0, 0);
    step("pop2",        0, 1, 0, 0, 32'h0,        0, 1, 32'h24,       2, 32'h20,       0, 0);
    step("pop3",        0, 1, 0, 0, 32'h0,        0, 1, 32'h20,       1, 32'h1C,       0, 0);
    step("pop4",        0, 1, 0, 0, 32'h0,        0, 1, 32'h1C,       0, 32'h0,        0, 0);
    step("pop5_under",  0, 1, 0, 0, 32'h0,        0, 1, 32'h20,       0, 32'h0,        0, 1);
    step("under_clr",   0, 1, 0, 0, 32'h0,        0, 0, 32'h24,       0, 32'h0,        0, 0);
    step("redir_103",   0, 1, 0, 1, 32'h103,      0, 0, 32'h100,      0, 32'h0,        1, 0);
    step("mis_clr",     0, 1, 0, 0, 32'h0,        0, 0, 32'h104,      0, 32'h0,        0, 0);
    step("to_3c",       0, 1, 0, 1, 32'h3C,       0, 0, 32'h3C,       0, 32'h0,        0, 0);
    step("call_3c",     0, 1, 0, 0, 32'h0,        1, 0, 32'h40,       1, 32'h40,       0, 0);
    step("to_20",       0, 1, 0, 1, 32'h20,       0, 0, 32'h20,       1, 32'h40,       0, 0);
    step("pushpop",     0, 1, 0, 0, 32'h0,        1, 1, 32'h40,       1, 32'h24,       0, 0);
    step("pop_24",      0, 1, 0, 0, 32'h0,        0, 1, 32'h24,       0, 32'h0,        0, 0);
    step("pushpop_emp", 0, 1, 0, 0, 32'h0,        1, 1, 32'h28,       1, 32'h28,       0, 0);
    step("redir_push",  0, 1, 0, 1, 32'h200,      1, 1, 32'h200,      1, 32'h28,       0, 0);
    step("stall_push",  0, 0, 0, 0, 32'h0,        1, 0, 32'h200,      1, 32'h28,       0, 0);
    step("trap_en",     0, 1, 1, 0, 32'h0,        1, 0, 32'h4,        0, 32'h0,        0, 0);
    step("to_top",      0, 1, 0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 32'h0,        0, 0);
    step("wrap",        0, 1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        0, 0);
    step("push_pre_rst",0, 1, 0, 0, 32'h0,        1, 0, 32'h4,        1, 32'h4,        0, 0);
    step("mid_reset",   1, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 0);
    @(negedge clk);
    rst = 1'b0; bus.pc_en = 1'b0; bus.ras_push = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    stim_done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
